// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: latches decode values and produces forwarded ALU operands.
// Latency: one cycle from decode inputs to portA/portB. Forwarding and stall are
//   combinational from the current stage registers and the current inputs.
// Backpressure: en=0 holds every stage register. A load-use hazard raises stall
//   and inserts one bubble. A flush squashes the decode instruction into a bubble.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   en, flush       pipeline advance (memory handshake), branch/jump squash
//   id_*            decode-stage operands, register numbers and controls
//   mem_*, wb_*     EX/MEM and MEM/WB writeback candidates for forwarding
//   portA, portB    ALU operands; ALUOP is the latched ALU operation
//   ex_*            latched controls and store data for the downstream stages
//   stall           load-use stall request to the IF/ID latch and the PC
module alu_operand_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wsel,
  input  logic [3:0]  id_aluop,
  input  logic        id_alu_src,
  input  logic        id_uses_rt,
  input  logic        id_reg_wen,
  input  logic        id_mem_read,
  input  logic        mem_wen,
  input  logic [4:0]  mem_wsel,
  input  logic [31:0] mem_result,
  input  logic        wb_wen,
  input  logic [4:0]  wb_wsel,
  input  logic [31:0] wb_result,
  output logic [31:0] portA,
  output logic [31:0] portB,
  output logic [3:0]  ALUOP,
  output logic        ex_valid,
  output logic        ex_reg_wen,
  output logic        ex_mem_read,
  output logic [4:0]  ex_wsel,
  output logic [31:0] ex_store_data,
  output logic        stall
);

  // A bubble carries the encoding of ALU_SLL (a shift of r0 by zero): a no-op.
  localparam logic [3:0] ALU_SLL = 4'd0;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imm_q,     imm_d;
  logic [4:0]  rs_q,      rs_d;
  logic [4:0]  rt_q,      rt_d;
  logic [4:0]  wsel_q,    wsel_d;
  logic [3:0]  aluop_q,   aluop_d;
  logic        alu_src_q, alu_src_d;
  logic        reg_wen_q, reg_wen_d;
  logic        mem_read_q, mem_read_d;
  logic        valid_q,   valid_d;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  // A load in EX cannot supply its data until after MEM, so a decode-stage
  // consumer of that register must wait one cycle. r0 is never a real
  // dependency. Only rt consumers that actually read rt count, so an
  // immediate-form instruction whose rt field happens to match does not stall.
  logic load_use;

  assign load_use = valid_q & mem_read_q & (wsel_q != 5'd0) &
                    ((wsel_q == id_rs) | (id_uses_rt & (wsel_q == id_rt)));

  // A flushed decode instruction is discarded anyway, so it never needs a stall.
  assign stall = load_use & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state selection
  // ---------------------------------------------------------------------------
  // Priority: flush, then hold on en=0, then load-use bubble, then load.
  // Reset is applied in the register process and sits above all of these.
  // Once a bubble is in EX, valid_q=0 clears load_use, so exactly one bubble
  // is inserted per hazard.
  logic load_bubble;
  logic load_decode;

  assign load_bubble = flush | (en & stall);
  assign load_decode = en & ~flush & ~stall;

  always_comb begin
    // default: hold
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    wsel_d     = wsel_q;
    aluop_d    = aluop_q;
    alu_src_d  = alu_src_q;
    reg_wen_d  = reg_wen_q;
    mem_read_d = mem_read_q;
    valid_d    = valid_q;

    if (load_bubble) begin
      rs_data_d  = 32'd0;
      rt_data_d  = 32'd0;
      imm_d      = 32'd0;
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      wsel_d     = 5'd0;
      aluop_d    = ALU_SLL;
      alu_src_d  = 1'b0;
      reg_wen_d  = 1'b0;
      mem_read_d = 1'b0;
      valid_d    = 1'b0;
    end else if (load_decode) begin
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = id_imm;
      rs_d       = id_rs;
      rt_d       = id_rt;
      wsel_d     = id_wsel;
      aluop_d    = id_aluop;
      alu_src_d  = id_alu_src;
      reg_wen_d  = id_reg_wen;
      mem_read_d = id_mem_read;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rs_data_q  <= 32'd0;
      rt_data_q  <= 32'd0;
      imm_q      <= 32'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      wsel_q     <= 5'd0;
      aluop_q    <= ALU_SLL;
      alu_src_q  <= 1'b0;
      reg_wen_q  <= 1'b0;
      mem_read_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wsel_q     <= wsel_d;
      aluop_q    <= aluop_d;
      alu_src_q  <= alu_src_d;
      reg_wen_q  <= reg_wen_d;
      mem_read_q <= mem_read_d;
      valid_q    <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  // EX/MEM holds the younger result, so it beats MEM/WB. A write to r0 is
  // architecturally discarded and is never forwarded.
  function automatic logic [31:0] forward(
    input logic [4:0]  src,
    input logic [31:0] latched,
    input logic        m_wen,
    input logic [4:0]  m_wsel,
    input logic [31:0] m_result,
    input logic        w_wen,
    input logic [4:0]  w_wsel,
    input logic [31:0] w_result
  );
    logic [31:0] value;
    value = latched;
    if (m_wen && (m_wsel != 5'd0) && (m_wsel == src)) begin
      value = m_result;
    end else if (w_wen && (w_wsel != 5'd0) && (w_wsel == src)) begin
      value = w_result;
    end
    return value;
  endfunction

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  assign fwd_a = forward(rs_q, rs_data_q, mem_wen, mem_wsel, mem_result,
                         wb_wen, wb_wsel, wb_result);
  assign fwd_b = forward(rt_q, rt_data_q, mem_wen, mem_wsel, mem_result,
                         wb_wen, wb_wsel, wb_result);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stores always need the register value of rt, even when the ALU takes
  // the immediate as its B operand for address generation.
  assign portA         = fwd_a;
  assign portB         = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;

  assign ALUOP       = aluop_q;
  assign ex_valid    = valid_q;
  assign ex_reg_wen  = reg_wen_q;
  assign ex_mem_read = mem_read_q;
  assign ex_wsel     = wsel_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam logic [3:0] ALU_SLL = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;

  logic        CLK = 1'b0;
  logic        RST, en, flush;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_wsel;
  logic [3:0]  id_aluop;
  logic        id_alu_src, id_uses_rt, id_reg_wen, id_mem_read;
  logic        mem_wen, wb_wen;
  logic [4:0]  mem_wsel, wb_wsel;
  logic [31:0] mem_result, wb_result;
  logic [31:0] portA, portB, ex_store_data;
  logic [3:0]  ALUOP;
  logic        ex_valid, ex_reg_wen, ex_mem_read, stall;
  logic [4:0]  ex_wsel;

  always #5 CLK = ~CLK;

  alu_operand_stage dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel), .id_aluop(id_aluop),
    .id_alu_src(id_alu_src), .id_uses_rt(id_uses_rt),
    .id_reg_wen(id_reg_wen), .id_mem_read(id_mem_read),
    .mem_wen(mem_wen), .mem_wsel(mem_wsel), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_result(wb_result),
    .portA(portA), .portB(portB), .ALUOP(ALUOP),
    .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read),
    .ex_wsel(ex_wsel), .ex_store_data(ex_store_data), .stall(stall)
  );

  typedef struct {
    logic [31:0] porta, portb, store;
    logic [3:0]  aluop;
    logic        valid, reg_wen, mem_read;
    logic [4:0]  wsel;
  } exp_t;

  typedef struct {
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, wsel;
    logic [3:0]  aluop;
    logic        alu_src, uses_rt, reg_wen, mem_read, en, flush, exp_stall;
    exp_t        e;
  } vec_t;

  localparam int NV = 17;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vt[NV];
  exp_t bub;

  function automatic exp_t mke(logic [31:0] a, logic [31:0] b, logic [31:0] s,
                               logic [3:0] op, logic v, logic rw, logic mr,
                               logic [4:0] ws);
    exp_t e;
    e.porta = a; e.portb = b; e.store = s; e.aluop = op;
    e.valid = v; e.reg_wen = rw; e.mem_read = mr; e.wsel = ws;
    return e;
  endfunction

  function automatic vec_t mkv(logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] ws,
                               logic [3:0] op, logic src, logic urt, logic rw,
                               logic mr, logic e_n, logic fl, logic st, exp_t e);
    vec_t v;
    v.rs_data = rsd; v.rt_data = rtd; v.imm = imm;
    v.rs = rs; v.rt = rt; v.wsel = ws; v.aluop = op;
    v.alu_src = src; v.uses_rt = urt; v.reg_wen = rw; v.mem_read = mr;
    v.en = e_n; v.flush = fl; v.exp_stall = st; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs_data  = v.rs_data;  id_rt_data = v.rt_data; id_imm = v.imm;
    id_rs       = v.rs;       id_rt      = v.rt;      id_wsel = v.wsel;
    id_aluop    = v.aluop;    id_alu_src = v.alu_src; id_uses_rt = v.uses_rt;
    id_reg_wen  = v.reg_wen;  id_mem_read = v.mem_read;
    en          = v.en;       flush      = v.flush;
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".portA"},    portA,         e.porta);
      chk({tag, ".portB"},    portB,         e.portb);
      chk({tag, ".store"},    ex_store_data, e.store);
      chk({tag, ".ALUOP"},    {28'd0, ALUOP},    {28'd0, e.aluop});
      chk({tag, ".valid"},    {31'd0, ex_valid},    {31'd0, e.valid});
      chk({tag, ".reg_wen"},  {31'd0, ex_reg_wen},  {31'd0, e.reg_wen});
      chk({tag, ".mem_read"}, {31'd0, ex_mem_read}, {31'd0, e.mem_read});
      chk({tag, ".wsel"},     {27'd0, ex_wsel},     {27'd0, e.wsel});
    end
  endtask

  initial begin
    exp_t e4;
    vec_t v;

    bub = mke(32'd0, 32'd0, 32'd0, ALU_SLL, 1'b0, 1'b0, 1'b0, 5'd0);
    e4  = mke(32'h11, 32'h22, 32'h22, ALU_OR, 1'b1, 1'b1, 1'b0, 5'd10);

    //            rs_data     rt_data     imm        rs  rt  ws  op       src urt rw mr en fl st  expected
    vt[0]  = mkv(32'd5,      32'd9,      32'd7,      1,  2,  4, ALU_ADD, 1, 0, 1, 0, 1, 0, 0,
                 mke(32'd5, 32'd7, 32'd9, ALU_ADD, 1, 1, 0, 5'd4));
    vt[1]  = mkv(32'h10,     32'h20,     32'hFFFF,   5,  6,  7, ALU_SUB, 0, 1, 1, 0, 1, 0, 0,
                 mke(32'h10, 32'h20, 32'h20, ALU_SUB, 1, 1, 0, 5'd7));
    vt[2]  = mkv(32'h100,    32'h200,    32'd4,      9,  8,  8, ALU_ADD, 1, 0, 1, 1, 1, 0, 0,
                 mke(32'h100, 32'd4, 32'h200, ALU_ADD, 1, 1, 1, 5'd8));
    vt[3]  = mkv(32'h11,     32'h22,     32'd0,      8,  3, 10, ALU_OR,  0, 1, 1, 0, 1, 0, 1, bub);
    vt[4]  = mkv(32'h11,     32'h22,     32'd0,      8,  3, 10, ALU_OR,  0, 1, 1, 0, 1, 0, 0, e4);
    vt[5]  = mkv(32'hDEAD,   32'hBEEF,   32'h5,     10, 11, 12, ALU_XOR, 1, 1, 1, 1, 0, 0, 0, e4);
    vt[6]  = mkv(32'hDEAD,   32'hBEEF,   32'h5,     10, 11, 12, ALU_XOR, 1, 1, 1, 1, 0, 0, 0, e4);
    vt[7]  = mkv(32'hDEAD,   32'hBEEF,   32'h5,     10, 11, 12, ALU_XOR, 1, 1, 1, 1, 0, 0, 0, e4);
    vt[8]  = mkv(32'hDEAD,   32'hBEEF,   32'h5,     10, 11, 12, ALU_XOR, 1, 1, 1, 1, 0, 1, 0, bub);
    vt[9]  = mkv(32'h33,     32'h44,     32'd8,      1, 12, 12, ALU_ADD, 1, 0, 1, 1, 1, 0, 0,
                 mke(32'h33, 32'd8, 32'h44, ALU_ADD, 1, 1, 1, 5'd12));
    vt[10] = mkv(32'h55,     32'h66,     32'd1,      2, 12, 13, ALU_AND, 1, 0, 1, 0, 1, 0, 0,
                 mke(32'h55, 32'd1, 32'h66, ALU_AND, 1, 1, 0, 5'd13));
    vt[11] = mkv(32'd0,      32'd0,      32'h10,     0,  0,  0, ALU_ADD, 1, 1, 1, 1, 1, 0, 0,
                 mke(32'd0, 32'h10, 32'd0, ALU_ADD, 1, 1, 1, 5'd0));
    vt[12] = mkv(32'h77,     32'h88,     32'd0,      0,  0,  3, ALU_XOR, 0, 1, 1, 0, 1, 0, 0,
                 mke(32'h77, 32'h88, 32'h88, ALU_XOR, 1, 1, 0, 5'd3));
    vt[13] = mkv(32'd1,      32'd2,      32'd0,      1,  2, 20, ALU_ADD, 1, 0, 1, 1, 1, 0, 0,
                 mke(32'd1, 32'd0, 32'd2, ALU_ADD, 1, 1, 1, 5'd20));
    vt[14] = mkv(32'h9,      32'h9,      32'd0,      5, 20, 22, ALU_AND, 0, 1, 1, 0, 1, 1, 0, bub);
    vt[15] = mkv(32'h3,      32'h4,      32'h20,     1,  2, 21, ALU_ADD, 1, 0, 1, 1, 1, 0, 0,
                 mke(32'h3, 32'h20, 32'h4, ALU_ADD, 1, 1, 1, 5'd21));
    vt[16] = mkv(32'h9,      32'h9,      32'd0,      1, 21, 22, ALU_AND, 0, 1, 1, 0, 1, 0, 1, bub);

    // reset
    RST = 1'b1;
    drive(mkv(0, 0, 0, 0, 0, 0, ALU_SLL, 0, 0, 0, 0, 1, 0, 0, bub));
    mem_wen = 1'b0; mem_wsel = 5'd0; mem_result = 32'd0;
    wb_wen  = 1'b0; wb_wsel  = 5'd0; wb_result  = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    sb.push_back(bub);
    pop_cmp("reset");
    chk("reset.stall", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // table-driven vectors, no forwarding sources active
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(vt[i]);
      #1;
      chk($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vt[i].exp_stall});
      sb.push_back(vt[i].e);
      @(posedge CLK);
      #1;
      pop_cmp($sformatf("vec%0d", i));
    end

    // forwarding priority: EX/MEM over MEM/WB, on both operands
    @(negedge CLK);
    drive(mkv(32'h1111, 32'h2222, 32'h99, 3, 4, 5, ALU_ADD, 0, 1, 1, 0, 1, 0, 0, bub));
    @(posedge CLK); #1;
    chk("fwd.raw_a", portA, 32'h1111);
    chk("fwd.raw_b", portB, 32'h2222);
    @(negedge CLK);
    en = 1'b0;
    mem_wen = 1'b1; mem_wsel = 5'd3; mem_result = 32'hAAAA;
    wb_wen  = 1'b1; wb_wsel  = 5'd3; wb_result  = 32'hBBBB;
    #1;
    chk("fwd.both_a", portA, 32'hAAAA);
    chk("fwd.both_b", portB, 32'h2222);
    @(negedge CLK);
    mem_wsel = 5'd0;
    #1;
    chk("fwd.wb_a", portA, 32'hBBBB);
    @(negedge CLK);
    mem_wsel = 5'd4; mem_result = 32'hCCCC; wb_wsel = 5'd4;
    #1;
    chk("fwd.mem_b_a", portA, 32'h1111);
    chk("fwd.mem_b_b", portB, 32'hCCCC);
    chk("fwd.mem_b_st", ex_store_data, 32'hCCCC);
    @(negedge CLK);
    mem_wen = 1'b0;
    #1;
    chk("fwd.wb_b", portB, 32'hBBBB);

    // register 0 is never forwarded
    @(negedge CLK);
    mem_wen = 1'b0; wb_wen = 1'b0;
    drive(mkv(32'd0, 32'd0, 32'd0, 0, 0, 6, ALU_ADD, 0, 1, 1, 0, 1, 0, 0, bub));
    @(posedge CLK); #1;
    @(negedge CLK);
    en = 1'b0;
    mem_wen = 1'b1; mem_wsel = 5'd0; mem_result = 32'h1234;
    wb_wen  = 1'b1; wb_wsel  = 5'd0; wb_result  = 32'h5678;
    #1;
    chk("zero.portA", portA, 32'd0);
    chk("zero.portB", portB, 32'd0);

    // reset overrides flush and a pending load-use stall
    @(negedge CLK);
    mem_wen = 1'b0; wb_wen = 1'b0;
    drive(mkv(32'd1, 32'd2, 32'd0, 1, 2, 8, ALU_ADD, 1, 0, 1, 1, 1, 0, 0, bub));
    @(posedge CLK); #1;
    chk("rst_seq.load_mr", {31'd0, ex_mem_read}, 32'd1);
    @(negedge CLK);
    v = mkv(32'h4242, 32'h17, 32'h3, 8, 2, 9, ALU_SUB, 0, 1, 1, 0, 1, 0, 0,
            mke(32'h4242, 32'h17, 32'h17, ALU_SUB, 1, 1, 0, 5'd9));
    drive(v);
    #1;
    chk("rst_seq.stall_pre", {31'd0, stall}, 32'd1);
    RST = 1'b1; flush = 1'b1;
    sb.push_back(bub);
    @(posedge CLK); #1;
    pop_cmp("rst_seq.bubble");
    chk("rst_seq.stall_post", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(v);
    #1;
    chk("rst_seq.stall_after", {31'd0, stall}, 32'd0);
    sb.push_back(v.e);
    @(posedge CLK); #1;
    pop_cmp("rst_seq.reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 en  in  1  pipeline advance from memory handshake (ihit/dhit); 0 = hold.
REQ-004 flush  in  1  branch/jump squash of the decode-stage instruction.
REQ-005 id_rs_data, id_rt_data, id_imm  in  32 each  decode register-file reads and extended immediate.
REQ-006 id_rs, id_rt, id_wsel  in  5 each  decode source and destination register numbers.
REQ-007 id_aluop  in  4  aluop_t from cpu_types_pkg.
REQ-008 id_alu_src, id_uses_rt, id_reg_wen, id_mem_read  in  1 each  decode controls.
REQ-009 mem_wen, mem_wsel, mem_result  in  1/5/32  EX/MEM writeback candidate.
REQ-010 wb_wen, wb_wsel, wb_result  in  1/5/32  MEM/WB writeback candidate.
REQ-011 portA, portB  out  32 each  ALU operands.
REQ-012 ALUOP  out  4  ALU operation.
REQ-013 ex_valid, ex_reg_wen, ex_mem_read  out  1 each  latched controls for downstream.
REQ-014 ex_wsel  out  5  latched destination register.
REQ-015 ex_store_data  out  32  forwarded rt value for stores.
REQ-016 stall  out  1  combinational load-use stall request to IF/ID latch and PC.

Function
REQ-017 Stage register SHALL hold rs_data, rt_data, imm, rs, rt, wsel, aluop, alu_src, reg_wen, mem_read, valid.
REQ-018 Update priority per edge SHALL be: RST > flush > en=0 hold > load-use bubble > load decode values.
REQ-019 flush=1 SHALL load a bubble regardless of en: valid=0, reg_wen=0, mem_read=0, aluop=ALU_SLL, data/reg fields 0.
REQ-020 en=0 with flush=0 SHALL leave every stage register unchanged.
REQ-021 stall SHALL be 1 iff ex_valid & ex_mem_read & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)), gated by flush=0.
REQ-022 stall=1 with en=1 SHALL load a bubble (as REQ-019) instead of decode values; one bubble per load-use, no repeated stall next cycle.
REQ-023 Forwarded A SHALL be mem_result if mem_wen & mem_wsel!=0 & mem_wsel==ex_rs; else wb_result if wb_wen & wb_wsel!=0 & wb_wsel==ex_rs; else latched rs_data.
REQ-024 Forwarded rt SHALL follow REQ-023 using ex_rt; EX/MEM always beats MEM/WB.
REQ-025 portA SHALL equal forwarded A; portB SHALL be latched imm if alu_src else forwarded rt; ex_store_data SHALL equal forwarded rt.
REQ-026 Forwarding and portA/portB/stall SHALL be combinational (zero-cycle) from current register and input values; register-to-ALU latency one cycle.
REQ-027 Register 0 SHALL never be forwarded nor trigger stall; raw latched value used.
REQ-028 ALUOP, ex_reg_wen, ex_mem_read, ex_wsel SHALL be driven directly from latched fields; bubble forces reg_wen=0, mem_read=0.

Reset
REQ-029 RST=1 at an edge SHALL clear all stage registers to bubble state: ex_valid=0, ex_reg_wen=0, ex_mem_read=0, ex_wsel=0, ALUOP=ALU_SLL, portA=portB=0 when no forwarding matches.
REQ-030 RST SHALL override flush, en and stall; a mid-stall reset leaves no pending bubble afterward.
REQ-031 stall SHALL be 0 in the cycle after reset (ex_valid=0).

Verification
REQ-032 Load: id_rs_data=5, id_imm=7, alu_src=1, aluop=ALU_ADD, en=1 -> next cycle portA=5, portB=7, ALUOP=ALU_ADD, ex_valid=1.
REQ-033 Double hazard: ex_rs=3, mem_wen=1 mem_wsel=3 mem_result=0xAAAA, wb_wen=1 wb_wsel=3 wb_result=0xBBBB -> portA=0xAAAA; mem_wsel=0 instead -> portA=0xBBBB.
REQ-034 Load-use: ex_mem_read=1 ex_wsel=8, id_rs=8, en=1 -> stall=1, next cycle ex_valid=0 ex_reg_wen=0, stall=0.
REQ-035 Zero reg: ex_rs=0, mem_wen=1 mem_wsel=0 mem_result=0x1234, latched rs_data=0 -> portA=0; ex_wsel=0 load + id_rs=0 -> stall=0.
REQ-036 Hold/flush: en=0 for 3 cycles -> outputs constant; flush=1 with en=0 -> next cycle ex_valid=0; RST=1 with flush=1 and stall=1 -> all bubble state.
